// File: rtl/tb_check_pkg.sv
// Shared types and helpers for the stream result checker and the benches that read its counters.
package tb_check_pkg;

  typedef enum logic [1:0] {
    V_PASS,
    V_FAIL,
    V_ORPHAN
  } verdict_e;

  localparam int CNT_W_DEF = 32;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] pass;
    logic [CNT_W_DEF-1:0] fail;
    logic [CNT_W_DEF-1:0] orphan;
  } ch_stats_t;

  // Counters stop at max_value instead of wrapping back to zero.
  function automatic logic [CNT_W_DEF-1:0] sat_inc(input logic [CNT_W_DEF-1:0] value,
                                                   input logic [CNT_W_DEF-1:0] max_value);
    return (value >= max_value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/chk_fifo.sv
// Single-channel expected-word FIFO; head is the oldest stored word, valid whenever empty is 0.
module chk_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until the pointers say it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/stream_result_checker.sv
// Multi-channel scoreboard: compares actual words against queued expected words and keeps
// saturating pass/fail/orphan counters, a first-fail record and a sticky halt flag.
module stream_result_checker
  import tb_check_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 32,
  parameter int MAX_FAIL = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       clear,
  input  logic [NUM_CH-1:0]                          exp_valid,
  output logic [NUM_CH-1:0]                          exp_ready,
  input  logic [NUM_CH*DATA_W-1:0]                   exp_data,
  input  logic [NUM_CH-1:0]                          act_valid,
  output logic [NUM_CH-1:0]                          act_ready,
  input  logic [NUM_CH*DATA_W-1:0]                   act_data,
  output logic [NUM_CH*CNT_W-1:0]                    pass_cnt,
  output logic [NUM_CH*CNT_W-1:0]                    fail_cnt,
  output logic [NUM_CH*CNT_W-1:0]                    orphan_cnt,
  output logic                                       ff_valid,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ff_ch,
  output logic [DATA_W-1:0]                          ff_exp,
  output logic [DATA_W-1:0]                          ff_act,
  output logic                                       halted,
  output logic                                       idle
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [SUM_W-1:0] MAX_FAIL_V = SUM_W'(MAX_FAIL);

  logic [DATA_W-1:0] exp_word  [NUM_CH];
  logic [DATA_W-1:0] act_word  [NUM_CH];
  logic [DATA_W-1:0] fifo_head [NUM_CH];
  logic              fifo_full [NUM_CH];
  logic              fifo_empty[NUM_CH];
  logic [NUM_CH-1:0] push, pop, accept;
  verdict_e          verdict   [NUM_CH];

  logic [CNT_W-1:0]  pass_q[NUM_CH],   pass_d[NUM_CH];
  logic [CNT_W-1:0]  fail_q[NUM_CH],   fail_d[NUM_CH];
  logic [CNT_W-1:0]  orphan_q[NUM_CH], orphan_d[NUM_CH];
  logic              ff_valid_q, ff_valid_d;
  logic [CH_W-1:0]   ff_ch_q, ff_ch_d;
  logic [DATA_W-1:0] ff_exp_q, ff_exp_d;
  logic [DATA_W-1:0] ff_act_q, ff_act_d;
  logic              halted_q, halted_d;
  logic [SUM_W-1:0]  fail_sum;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign exp_word[g] = exp_data[g*DATA_W +: DATA_W];
    assign act_word[g] = act_data[g*DATA_W +: DATA_W];
    assign pass_cnt[g*CNT_W +: CNT_W]   = pass_q[g];
    assign fail_cnt[g*CNT_W +: CNT_W]   = fail_q[g];
    assign orphan_cnt[g*CNT_W +: CNT_W] = orphan_q[g];

    chk_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .push      (push[g]),
      .pop       (pop[g]),
      .push_data (exp_word[g]),
      .head      (fifo_head[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );
  end

  // Channels are walked in ascending order so the lowest failing index claims the first-fail record.
  always_comb begin
    exp_ready  = '0;
    act_ready  = '0;
    push       = '0;
    pop        = '0;
    accept     = '0;
    idle       = 1'b1;
    pass_d     = pass_q;
    fail_d     = fail_q;
    orphan_d   = orphan_q;
    ff_valid_d = ff_valid_q;
    ff_ch_d    = ff_ch_q;
    ff_exp_d   = ff_exp_q;
    ff_act_d   = ff_act_q;
    halted_d   = halted_q;
    fail_sum   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_ready[c] = !fifo_full[c] && !halted_q;
      act_ready[c] = !halted_q;
      push[c]      = exp_valid[c] && exp_ready[c] && !clear;
      accept[c]    = act_valid[c] && act_ready[c] && !clear;
      pop[c]       = accept[c] && !fifo_empty[c];
      idle         = idle && fifo_empty[c];
      if (fifo_empty[c])                    verdict[c] = V_ORPHAN;
      else if (fifo_head[c] == act_word[c]) verdict[c] = V_PASS;
      else                                  verdict[c] = V_FAIL;
      if (accept[c]) begin
        if (verdict[c] == V_PASS) begin
          pass_d[c] = CNT_W'(sat_inc(CNT_W_DEF'(pass_q[c]), CNT_W_DEF'(CNT_MAX)));
        end else begin
          fail_d[c] = CNT_W'(sat_inc(CNT_W_DEF'(fail_q[c]), CNT_W_DEF'(CNT_MAX)));
          if (verdict[c] == V_ORPHAN)
            orphan_d[c] = CNT_W'(sat_inc(CNT_W_DEF'(orphan_q[c]), CNT_W_DEF'(CNT_MAX)));
          if (!ff_valid_d) begin
            ff_valid_d = 1'b1;
            ff_ch_d    = CH_W'(c);
            ff_exp_d   = (verdict[c] == V_ORPHAN) ? '0 : fifo_head[c];
            ff_act_d   = act_word[c];
          end
        end
      end
      fail_sum = fail_sum + SUM_W'(fail_d[c]);
    end
    if ((MAX_FAIL != 0) && (fail_sum >= MAX_FAIL_V)) halted_d = 1'b1;
    if (clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pass_d[c]   = '0;
        fail_d[c]   = '0;
        orphan_d[c] = '0;
      end
      ff_valid_d = 1'b0;
      ff_ch_d    = '0;
      ff_exp_d   = '0;
      ff_act_d   = '0;
      halted_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pass_q[c]   <= '0;
        fail_q[c]   <= '0;
        orphan_q[c] <= '0;
      end
      ff_valid_q <= 1'b0;
      ff_ch_q    <= '0;
      ff_exp_q   <= '0;
      ff_act_q   <= '0;
      halted_q   <= 1'b0;
    end else begin
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      orphan_q   <= orphan_d;
      ff_valid_q <= ff_valid_d;
      ff_ch_q    <= ff_ch_d;
      ff_exp_q   <= ff_exp_d;
      ff_act_q   <= ff_act_d;
      halted_q   <= halted_d;
    end
  end

  assign ff_valid = ff_valid_q;
  assign ff_ch    = ff_ch_q;
  assign ff_exp   = ff_exp_q;
  assign ff_act   = ff_act_q;
  assign halted   = halted_q;

endmodule

// File: doc/stream_result_checker.md
Name: stream_result_checker

Overview:
- Synthesisable, multi-channel pass/fail scoreboard for self-checking benches and on-FPGA test harnesses.
- Per channel: buffers expected words, compares each incoming actual word against the oldest expected word, and keeps saturating pass/fail/orphan counters.
- Captures details of the first mismatch and can halt the stimulus path after a programmable failure count.
- Sits between the stimulus generator/golden model and the DUT output streams; its counters feed the end-of-test result report.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- DATA_W, 32, width of compared data words.
- DEPTH, 8, expected-word FIFO depth per channel (power of 2, >=2).
- CNT_W, 32, width of every counter.
- MAX_FAIL, 0, total-fail count that triggers halt; 0 disables halting.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of all state.
- exp_valid  in  NUM_CH  expected word valid, per channel.
- exp_ready  out  NUM_CH  expected FIFO can accept.
- exp_data  in  NUM_CH*DATA_W  expected words; channel c occupies bits [c*DATA_W +: DATA_W].
- act_valid  in  NUM_CH  actual word valid, per channel.
- act_ready  out  NUM_CH  actual word accepted.
- act_data  in  NUM_CH*DATA_W  actual words; same packing as exp_data.
- pass_cnt  out  NUM_CH*CNT_W  per-channel match count.
- fail_cnt  out  NUM_CH*CNT_W  per-channel mismatch count; includes orphans.
- orphan_cnt  out  NUM_CH*CNT_W  per-channel count of actual words arriving with no expected word.
- ff_valid  out  1  first-fail record is valid.
- ff_ch  out  $clog2(NUM_CH) (min 1)  channel of the first fail.
- ff_exp  out  DATA_W  expected word of the first fail (0 for an orphan).
- ff_act  out  DATA_W  actual word of the first fail.
- halted  out  1  fail threshold reached.
- idle  out  1  all expected FIFOs empty.

Behaviour:
- Reset (async, rst=1): all FIFOs empty; all counters 0; ff_* 0; halted 0; idle 1; exp_ready all 1; act_ready all 1.
- clear=1: same effect as reset, applied at the clock edge. Takes priority over any handshake in the same cycle; those handshakes are dropped and not counted.
- Expected push:
  - exp_ready[c] = !full[c] && !halted.
  - A push occurs on exp_valid[c] && exp_ready[c].
- Actual accept:
  - act_ready[c] = !halted.
  - On act_valid[c] && act_ready[c]:
    - FIFO non-empty: pop the head and compare it with act_data. Equal gives pass_cnt[c]+1; unequal gives fail_cnt[c]+1.
    - FIFO empty: orphan. orphan_cnt[c]+1 and fail_cnt[c]+1.
- No bypass: a push and an accept on an empty channel in the same cycle is an orphan; the pushed word is still stored.
- Push and pop in the same cycle on a non-empty FIFO: occupancy unchanged. On a full FIFO, exp_ready is 0 even if a pop occurs (no ready-on-pop).
- Latency: counters, ff_*, halted and idle are registered and update exactly 1 cycle after the handshake edge.
- Counters saturate at 2^CNT_W-1 and never wrap.
- First fail:
  - Captured only while ff_valid=0, then held until reset/clear.
  - If several channels fail in the same cycle, the lowest channel index wins.
- Halt:
  - When MAX_FAIL!=0 and the sum of all fail_cnt (computed with saturation) becomes >=MAX_FAIL, halted goes to 1 on the next edge and is sticky.
  - Handshakes already in the cycle that trips the threshold complete and are counted.
- idle = AND of all FIFO-empty flags.

Decomposition:
- Package tb_check_pkg:
  - verdict_e enum {V_PASS, V_FAIL, V_ORPHAN}.
  - CNT_W_DEF=32.
  - ch_stats_t packed struct {pass, fail, orphan} of CNT_W_DEF bits each, for bench-side unpacking.
  - Saturating-increment function sat_inc.
- Sub-module chk_fifo:
  - Single-channel synchronous FIFO, DATA_W x DEPTH.
  - Ports: push, pop, full, empty, head.
  - Instantiated NUM_CH times via generate.

Test Plan:
- Ch0: push 0x11, 0x22; actual 0x11, 0x22 -> pass_cnt[0]=2, fail_cnt[0]=0, ff_valid=0, idle=1 one cycle after the last accept.
- Ch1: push 0xAA; actual 0xAB -> fail_cnt[1]=1, ff_ch=1, ff_exp=0xAA, ff_act=0xAB. A later ch2 mismatch leaves the record unchanged.
- Ch3 empty: actual 0x5 -> orphan_cnt[3]=1, fail_cnt[3]=1, ff_exp=0. Same-cycle push 0x5 + actual 0x5 on an empty ch0 -> orphan, and FIFO holds 0x5.
- Push 8 words into ch2 -> exp_ready[2]=0. Simultaneous 9th push + pop -> 9th push not accepted, occupancy 7.
- MAX_FAIL=2: mismatches on ch0 and ch1 in the same cycle -> halted=1 next cycle, ff_ch=0, all ready outputs 0. Then assert clear -> all counters 0, halted=0, ready outputs 1.
- Saturation (CNT_W=4): 17 matches on ch0 -> pass_cnt[0]=15. Async rst mid-stream -> all outputs at reset values without waiting for a clock edge.
